// File: rtl/fir_err_pkg.sv
// Shared types, widths and helpers for the FIR error monitor.
package fir_err_pkg;

  typedef enum logic [1:0] {IDLE, WARMUP, MEASURE, DONE} err_state_t;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned ERR_W    = 17;
  localparam int unsigned SUM_W    = 32;

  // |e| cannot overflow: e lies in -65535..65535.
  function automatic logic [ERR_W-1:0] abs17(input logic [ERR_W-1:0] e);
    return e[ERR_W-1] ? (~e + 17'd1) : e;
  endfunction

endpackage

// File: rtl/fir_abs_diff.sv
// Combinational |a - b| of two signed 16-bit samples, plus a nonzero flag.
module fir_abs_diff
  import fir_err_pkg::*;
(
  input  logic [SAMPLE_W-1:0] a,
  input  logic [SAMPLE_W-1:0] b,
  output logic [ERR_W-1:0]    mag,
  output logic                nz
);

  logic [ERR_W-1:0] e;

  assign e   = {a[SAMPLE_W-1], a} - {b[SAMPLE_W-1], b};
  assign mag = abs17(e);
  assign nz  = |e;

endmodule

// File: rtl/fir_error_monitor.sv
// Error metrics (sum, max, nonzero count, mean of |y_apx - y_ref|) over a fixed
// window that follows a warmup period of discarded samples.
module fir_error_monitor
  import fir_err_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES = 1024,
  parameter int unsigned WARMUP      = 9
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                start,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] y_apx,
  input  logic [SAMPLE_W-1:0] y_ref,
  output logic                busy,
  output logic                done,
  output logic [SUM_W-1:0]    err_sum,
  output logic [ERR_W-1:0]    err_max,
  output logic [ERR_W-1:0]    err_cnt,
  output logic [SUM_W-1:0]    err_mean
);

  localparam int unsigned MeanShift = $clog2(NUM_SAMPLES);
  localparam logic [7:0]       WarmupW = 8'(WARMUP);
  localparam logic [ERR_W-1:0] NumW    = ERR_W'(NUM_SAMPLES);

  err_state_t       state_q, state_d;
  logic [7:0]       warm_cnt_q, warm_cnt_d;
  logic [ERR_W-1:0] meas_cnt_q, meas_cnt_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [ERR_W-1:0] max_q, max_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [ERR_W-1:0] mag;
  logic             nz;

  fir_abs_diff u_abs_diff (
    .a   (y_apx),
    .b   (y_ref),
    .mag (mag),
    .nz  (nz)
  );

  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    meas_cnt_d = meas_cnt_q;
    sum_d      = sum_q;
    max_d      = max_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          warm_cnt_d = '0;
          meas_cnt_d = '0;
          sum_d      = '0;
          max_d      = '0;
          cnt_d      = '0;
          done_d     = 1'b0;
          state_d    = (WARMUP == 0) ? MEASURE : fir_err_pkg::WARMUP;
        end
      end
      fir_err_pkg::WARMUP: begin
        if (sample_valid) begin
          warm_cnt_d = warm_cnt_q + 8'd1;
          if (warm_cnt_d == WarmupW) state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (sample_valid) begin
          sum_d      = sum_q + SUM_W'(mag);
          max_d      = (mag > max_q) ? mag : max_q;
          cnt_d      = cnt_q + ERR_W'(nz);
          meas_cnt_d = meas_cnt_q + 17'd1;
          if (meas_cnt_d == NumW) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == fir_err_pkg::WARMUP) || (state_d == MEASURE);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= IDLE;
      warm_cnt_q <= '0;
      meas_cnt_q <= '0;
      sum_q      <= '0;
      max_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      meas_cnt_q <= meas_cnt_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err_sum  = sum_q;
  assign err_max  = max_q;
  assign err_cnt  = cnt_q;
  assign err_mean = sum_q >> MeanShift;

endmodule

// File: tb/tb_fir_error_monitor.sv
// Randomized and directed bench for fir_error_monitor against a queue-based model.
module tb_fir_error_monitor;

  localparam int unsigned NS    = 8;
  localparam int unsigned WU    = 2;
  localparam int unsigned TOTAL = NS + WU;

  logic               clk = 1'b0;
  logic               rstN = 1'b1;
  logic               start = 1'b0;
  logic               sample_valid = 1'b0;
  logic signed [15:0] y_apx = '0;
  logic signed [15:0] y_ref = '0;
  logic               busy, done;
  logic [31:0]        err_sum, err_mean;
  logic [16:0]        err_max, err_cnt;

  fir_error_monitor #(
    .NUM_SAMPLES (NS),
    .WARMUP      (WU)
  ) dut (
    .clk          (clk),
    .rstN         (rstN),
    .start        (start),
    .sample_valid (sample_valid),
    .y_apx        (y_apx),
    .y_ref        (y_ref),
    .busy         (busy),
    .done         (done),
    .err_sum      (err_sum),
    .err_max      (err_max),
    .err_cnt      (err_cnt),
    .err_mean     (err_mean)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: a run is the list of |e| values accepted since the last start.
  // The first WU entries are warmup; the run is complete at TOTAL entries.
  int unsigned q[$];
  bit          m_active = 1'b0;

  function automatic int unsigned absdiff(input logic signed [15:0] a,
                                          input logic signed [15:0] b);
    int e;
    e = int'(a) - int'(b);
    return (e < 0) ? int'(-e) : e;
  endfunction

  function automatic bit m_busy();
    return m_active && (q.size() < TOTAL);
  endfunction

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      m_active <= 1'b0;
      q.delete();
    end else if (start && !m_busy()) begin
      m_active <= 1'b1;
      q.delete();
    end else if (sample_valid && m_busy()) begin
      q.push_back(absdiff(y_apx, y_ref));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int unsigned s, mx, c;
      s = 0; mx = 0; c = 0;
      for (int i = WU; i < q.size(); i++) begin
        s += q[i];
        if (q[i] > mx) mx = q[i];
        if (q[i] != 0) c++;
      end
      chk("busy", 32'(busy), 32'(m_busy()));
      chk("done", 32'(done), 32'(m_active && q.size() == TOTAL));
      chk("err_sum", err_sum, s);
      chk("err_max", 32'(err_max), mx);
      chk("err_cnt", 32'(err_cnt), c);
      if (m_active && q.size() == TOTAL) chk("err_mean", err_mean, s >> 3);
    end
  end

  task automatic step(input bit v, input bit s, input logic signed [15:0] a,
                      input logic signed [15:0] r);
    @(negedge clk);
    #1;
    sample_valid = v;
    start        = s;
    y_apx        = a;
    y_ref        = r;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 16'($urandom), 16'($urandom));
  endtask

  task automatic lit(input string tag, input logic [31:0] s, input logic [31:0] m,
                     input logic [31:0] c, input logic [31:0] mean);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_sum"}, err_sum, s);
    chk({tag, "_max"}, 32'(err_max), m);
    chk({tag, "_cnt"}, 32'(err_cnt), c);
    chk({tag, "_mean"}, err_mean, mean);
  endtask

  // Test-3 pattern; toggle inserts an idle cycle after every valid one and
  // pulses start during the run.
  task automatic run3(input bit toggle);
    logic signed [15:0] r;
    step(1'b0, 1'b1, 16'sd0, 16'sd0);
    for (int i = 0; i < TOTAL; i++) begin
      r = 16'($urandom_range(0, 2000)) - 16'sd1000;
      if (i < WU) step(1'b1, 1'b0, 16'sd600, 16'sd100);
      else        step(1'b1, 1'b0, r + 16'sd3, r);
      if (toggle) begin
        if (i == 5) step(1'b0, 1'b1, 16'($urandom), 16'($urandom));
        else        idle_step();
      end
    end
    if (!toggle) idle_step();
  endtask

  initial begin
    logic signed [15:0] r, a;
    #1 rstN = 1'b0;
    for (int i = 0; i < 3; i++) step(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
    chk_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", err_sum, 32'd0);
    step(1'b0, 1'b0, 16'sd0, 16'sd0);
    rstN = 1'b1;

    // All-equal window.
    step(1'b0, 1'b1, 16'sd0, 16'sd0);
    for (int i = 0; i < TOTAL; i++) step(1'b1, 1'b0, 16'sd100, 16'sd100);
    idle_step();
    lit("t2", 32'd0, 32'd0, 32'd0, 32'd0);

    run3(1'b0);
    lit("t3", 32'd24, 32'd3, 32'd8, 32'd3);

    // Extreme difference once in the window.
    step(1'b0, 1'b1, 16'sd0, 16'sd0);
    for (int i = 0; i < TOTAL; i++) begin
      if (i == 6) step(1'b1, 1'b0, 16'sh7FFF, 16'sh8000);
      else        step(1'b1, 1'b0, 16'sd42, 16'sd42);
    end
    idle_step();
    lit("t4", 32'd65535, 32'h0FFFF, 32'd1, 32'd8191);

    run3(1'b1);
    lit("t5", 32'd24, 32'd3, 32'd8, 32'd3);

    // Reset after four measured samples.
    step(1'b0, 1'b1, 16'sd0, 16'sd0);
    for (int i = 0; i < WU + 4; i++) step(1'b1, 1'b0, 16'sd10, 16'sd3);
    @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_sum", err_sum, 32'd0);
    chk("t6_cnt", 32'(err_cnt), 32'd0);
    idle_step();
    rstN = 1'b1;
    run3(1'b0);
    lit("t6r", 32'd24, 32'd3, 32'd8, 32'd3);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      r = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       a = r;
        1:       a = 16'($urandom);
        default: a = r + 16'($urandom_range(0, 40)) - 16'sd20;
      endcase
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), a, r);
    end
    idle_step();
    idle_step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
